// File: rtl/uart_avms_master.sv
// uart_avms_master: Avalon-MM master that turns uart_core register accesses into
// a TX byte stream (FIFO + STATUS polling) and an RX byte stream (IRQ-driven reads).
module uart_avms_master #(
  parameter int unsigned TX_DEPTH     = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned POLL_GAP     = 3
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic [7:0] s_tx_data_i,
  input  logic       s_tx_valid_i,
  output logic       s_tx_ready_o,
  output logic [7:0] m_rx_data_o,
  output logic       m_rx_valid_o,
  input  logic       m_rx_ready_i,
  output logic [3:0] avm_address_o,
  output logic       avm_byteenable_o,
  output logic       avm_read_o,
  output logic       avm_write_o,
  output logic [7:0] avm_writedata_o,
  input  logic [7:0] avm_readdata_i,
  input  logic       irq_i,
  output logic [7:0] rx_drop_cnt_o,
  output logic       busy_o
);

  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_RXDATA = 4'h2;

  typedef enum logic [2:0] {
    IDLE, GAP, ST_RD, ST_WAIT, TX_WR, RX_RD, RX_WAIT
  } state_e;

  state_e         state_q;
  logic [GW-1:0]  gap_q;
  logic [1:0]     lat_q;
  logic [1:0]     mask_q;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     mem_q [TX_DEPTH];
  logic           tx_ready_q, busy_q;
  logic           read_q, write_q, be_q;
  logic [3:0]     addr_q;
  logic [7:0]     wdata_q, rx_data_q, drop_q;
  logic           rx_valid_q;
  logic           push, pop;

  assign push = s_tx_valid_i && tx_ready_q;
  assign pop  = (state_q == TX_WR);

  // Next FIFO occupancy; push and pop together leave it unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // FIFO storage, written on accepted pushes
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_tx_data_i;
  end

  // FIFO pointers, occupancy and the registered ready/busy flags
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q      <= cnt_d;
      tx_ready_q <= (cnt_d != CW'(TX_DEPTH));
      busy_q     <= (state_q != IDLE) || (cnt_d != '0);
    end
  end

  // Bus sequencer: strobes are set on entry to the state they belong to
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      gap_q      <= GW'(POLL_GAP);
      lat_q      <= '0;
      mask_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      be_q       <= 1'b0;
      addr_q     <= ADDR_STATUS;
      wdata_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      be_q    <= 1'b0;
      addr_q  <= ADDR_STATUS;
      if (mask_q != '0) mask_q <= mask_q - 2'd1;
      if (rx_valid_q && m_rx_ready_i) rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (irq_i && (mask_q == '0)) begin
            state_q <= RX_RD;
            read_q  <= 1'b1;
            addr_q  <= ADDR_RXDATA;
          end else if (cnt_q != '0) begin
            if (POLL_GAP == 0) begin
              state_q <= ST_RD;
              read_q  <= 1'b1;
            end else begin
              state_q <= GAP;
              gap_q   <= GW'(POLL_GAP);
            end
          end
        end
        GAP: begin
          if (gap_q <= GW'(1)) begin
            state_q <= ST_RD;
            read_q  <= 1'b1;
            gap_q   <= GW'(POLL_GAP);
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        ST_RD: begin
          state_q <= ST_WAIT;
          lat_q   <= 2'(READ_LATENCY - 1);
        end
        ST_WAIT: begin
          if (lat_q == '0) begin
            if (avm_readdata_i[0]) begin
              state_q <= TX_WR;
              write_q <= 1'b1;
              be_q    <= 1'b1;
              addr_q  <= ADDR_TXDATA;
              wdata_q <= mem_q[rd_ptr_q];
            end else begin
              state_q <= IDLE;
            end
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        TX_WR: state_q <= IDLE;
        RX_RD: begin
          state_q <= RX_WAIT;
          lat_q   <= 2'(READ_LATENCY - 1);
        end
        RX_WAIT: begin
          if (lat_q == '0) begin
            state_q <= IDLE;
            mask_q  <= 2'd2;
            if (!rx_valid_q || m_rx_ready_i) begin
              rx_data_q  <= avm_readdata_i;
              rx_valid_q <= 1'b1;
            end else if (drop_q != 8'hFF) begin
              drop_q <= drop_q + 8'd1;
            end
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_tx_ready_o     = tx_ready_q;
  assign busy_o           = busy_q;
  assign avm_read_o       = read_q;
  assign avm_write_o      = write_q;
  assign avm_byteenable_o = be_q;
  assign avm_address_o    = addr_q;
  assign avm_writedata_o  = wdata_q;
  assign m_rx_data_o      = rx_data_q;
  assign m_rx_valid_o     = rx_valid_q;
  assign rx_drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_uart_avms_master.sv
// Self-checking bench for uart_avms_master with a uart_core register model.
module tb_uart_avms_master;
  localparam int unsigned TX_DEPTH     = 16;
  localparam int unsigned READ_LATENCY = 1;
  localparam int unsigned POLL_GAP     = 3;

  logic       clk_i, arst_n_i;
  logic [7:0] s_tx_data_i;
  logic       s_tx_valid_i, s_tx_ready_o;
  logic [7:0] m_rx_data_o;
  logic       m_rx_valid_o, m_rx_ready_i;
  logic [3:0] avm_address_o;
  logic       avm_byteenable_o, avm_read_o, avm_write_o;
  logic [7:0] avm_writedata_o, avm_readdata_i;
  logic       irq_i;
  logic [7:0] rx_drop_cnt_o;
  logic       busy_o;

  uart_avms_master #(.TX_DEPTH(TX_DEPTH), .READ_LATENCY(READ_LATENCY), .POLL_GAP(POLL_GAP)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .s_tx_data_i(s_tx_data_i), .s_tx_valid_i(s_tx_valid_i), .s_tx_ready_o(s_tx_ready_o),
    .m_rx_data_o(m_rx_data_o), .m_rx_valid_o(m_rx_valid_o), .m_rx_ready_i(m_rx_ready_i),
    .avm_address_o(avm_address_o), .avm_byteenable_o(avm_byteenable_o),
    .avm_read_o(avm_read_o), .avm_write_o(avm_write_o),
    .avm_writedata_o(avm_writedata_o), .avm_readdata_i(avm_readdata_i),
    .irq_i(irq_i), .rx_drop_cnt_o(rx_drop_cnt_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Register-model knobs owned by the stimulus block
  logic       st_val = 1'b1;
  logic       st_rand = 1'b0;
  int         zero_until = 0;
  logic [7:0] rx_byte = 8'h00;

  // Bus observations owned by the monitor block
  int         w_cnt = 0, r1_cnt = 0, r2_cnt = 0, proto_err = 0, idle_run = 100;
  logic       st_ok = 1'b0;
  logic [7:0] rd_b;
  logic [7:0] wr_data_log [256];
  logic [3:0] wr_addr_log [256];
  logic       wr_be_log   [256];

  int n_checks = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int rd_idx = 0;

  // uart_core register model plus bus protocol monitor
  always @(posedge clk_i) begin
    if (arst_n_i) begin
      if (avm_read_o && avm_write_o) proto_err++;
      if (!avm_read_o && !avm_write_o) begin
        if (avm_address_o != 4'h1) proto_err++;
        idle_run++;
      end else begin
        if (avm_read_o && avm_address_o == 4'h1) begin
          if (idle_run < int'(POLL_GAP)) proto_err++;
          rd_b = 8'($urandom);
          if (r1_cnt < zero_until) rd_b[0] = 1'b0;
          else if (st_rand)        rd_b[0] = 1'($urandom_range(0, 1));
          else                     rd_b[0] = st_val;
          st_ok = rd_b[0];
          avm_readdata_i <= rd_b;
          r1_cnt++;
        end else if (avm_read_o && avm_address_o == 4'h2) begin
          avm_readdata_i <= rx_byte;
          r2_cnt++;
        end else if (avm_read_o) begin
          proto_err++;
        end
        if (avm_write_o) begin
          if (!st_ok) proto_err++;
          st_ok = 1'b0;
          if (w_cnt < 256) begin
            wr_data_log[w_cnt] = avm_writedata_o;
            wr_addr_log[w_cnt] = avm_address_o;
            wr_be_log[w_cnt]   = avm_byteenable_o;
          end
          w_cnt++;
        end
        idle_run = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bit acc = 1'b0;
    int g = 0;
    @(negedge clk_i);
    s_tx_data_i  = b;
    s_tx_valid_i = 1'b1;
    while (!acc && g < 300) begin
      acc = s_tx_ready_o;
      @(posedge clk_i);
      g++;
      if (!acc) @(negedge clk_i);
    end
    #1 s_tx_valid_i = 1'b0;
    if (acc) exp_q.push_back(b);
    chk("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_writes(input int n);
    int g = 0;
    while (w_cnt < n && g < 3000) begin
      @(negedge clk_i);
      g++;
    end
    repeat (5) @(negedge clk_i);
    chk("wr_count", 32'(w_cnt), 32'(n));
  endtask

  // Compare every newly logged write against the model's FIFO order
  task automatic check_writes();
    while (rd_idx < w_cnt && rd_idx < 256) begin
      chk("wr_addr", 32'(wr_addr_log[rd_idx]), 32'd0);
      chk("wr_be", 32'(wr_be_log[rd_idx]), 32'd1);
      if (exp_q.size() == 0) chk("wr_extra", 32'(exp_q.size()), 32'd1);
      else chk("wr_data", 32'(wr_data_log[rd_idx]), 32'(exp_q.pop_front()));
      rd_idx++;
    end
    chk("wr_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_read(input logic [3:0] want, output logic [3:0] a);
    int g = 0;
    a = 4'hE;
    while (g < 500) begin
      @(negedge clk_i);
      g++;
      if (avm_read_o && (want == 4'hF || avm_address_o == want)) begin
        a = avm_address_o;
        break;
      end
    end
  endtask

  task automatic rx_irq(input logic [7:0] b);
    logic [3:0] a;
    rx_byte = b;
    irq_i   = 1'b1;
    wait_read(4'h2, a);
    chk("rx_read_seen", 32'(a), 32'h2);
    @(negedge clk_i);
    irq_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic consume();
    m_rx_ready_i = 1'b1;
    @(negedge clk_i);
    m_rx_ready_i = 1'b0;
    chk("rx_valid_clear", 32'(m_rx_valid_o), 32'd0);
  endtask

  initial begin
    logic [3:0] a;
    logic [7:0] b;
    int r0, w0, g;
    arst_n_i = 1'b0; s_tx_valid_i = 1'b0; s_tx_data_i = 8'h00;
    m_rx_ready_i = 1'b0; irq_i = 1'b0; avm_readdata_i = 8'h00;
    #12;
    chk("rst_read", 32'(avm_read_o), 32'd0);
    chk("rst_write", 32'(avm_write_o), 32'd0);
    chk("rst_addr", 32'(avm_address_o), 32'h1);
    chk("rst_wdata", 32'(avm_writedata_o), 32'd0);
    chk("rst_be", 32'(avm_byteenable_o), 32'd0);
    chk("rst_rx_valid", 32'(m_rx_valid_o), 32'd0);
    chk("rst_rx_data", 32'(m_rx_data_o), 32'd0);
    chk("rst_drop", 32'(rx_drop_cnt_o), 32'd0);
    chk("rst_ready", 32'(s_tx_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i) arst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);

    // Three bytes with STATUS always ready
    push(8'h48); push(8'h45); push(8'h4C);
    wait_writes(3);
    check_writes();

    // Five not-ready polls, then ready: six STATUS reads, one write
    repeat (5) @(negedge clk_i);
    zero_until = r1_cnt + 5;
    r0 = r1_cnt; w0 = w_cnt;
    push(8'($urandom));
    wait_writes(w0 + 1);
    repeat (10) @(negedge clk_i);
    chk("poll_count", 32'(r1_cnt - r0), 32'd6);
    check_writes();

    // Fill the FIFO while STATUS blocks transmission
    st_val = 1'b0;
    w0 = w_cnt;
    for (int i = 0; i < int'(TX_DEPTH); i++) push(8'($urandom));
    @(negedge clk_i);
    chk("full_ready", 32'(s_tx_ready_o), 32'd0);
    s_tx_data_i = 8'($urandom); s_tx_valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("full_hold", 32'(s_tx_ready_o), 32'd0);
    s_tx_valid_i = 1'b0;
    st_val = 1'b1;
    g = 0;
    while (!s_tx_ready_o && g < 200) begin @(negedge clk_i); g++; end
    chk("ready_after_pop", 32'(s_tx_ready_o), 32'd1);
    wait_writes(w0 + int'(TX_DEPTH));
    check_writes();

    // IRQ arriving mid-poll is served before the next STATUS poll
    st_val = 1'b0;
    w0 = w_cnt;
    push(8'($urandom)); push(8'($urandom));
    wait_read(4'h1, a);
    irq_i = 1'b1; rx_byte = 8'h5A;
    wait_read(4'hF, a);
    chk("irq_first_addr", 32'(a), 32'h2);
    @(negedge clk_i) irq_i = 1'b0;
    @(negedge clk_i);
    chk("rx_valid_5a", 32'(m_rx_valid_o), 32'd1);
    chk("rx_data_5a", 32'(m_rx_data_o), 32'h5A);
    consume();
    st_val = 1'b1;
    wait_writes(w0 + 2);
    check_writes();

    // Random RX bytes, each consumed before the next arrives
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      rx_irq(b);
      chk("rx_valid_rand", 32'(m_rx_valid_o), 32'd1);
      chk("rx_data_rand", 32'(m_rx_data_o), 32'(b));
      consume();
      repeat (3) @(negedge clk_i);
    end
    chk("drop_zero", 32'(rx_drop_cnt_o), 32'd0);

    // Consumer stalled: second byte is dropped, first is held
    rx_irq(8'h11);
    chk("rx_data_11", 32'(m_rx_data_o), 32'h11);
    repeat (4) @(negedge clk_i);
    rx_irq(8'h22);
    repeat (2) @(negedge clk_i);
    chk("rx_hold_valid", 32'(m_rx_valid_o), 32'd1);
    chk("rx_hold_data", 32'(m_rx_data_o), 32'h11);
    chk("drop_one", 32'(rx_drop_cnt_o), 32'd1);
    consume();

    // Random STATUS readiness with random TX bytes
    st_rand = 1'b1;
    w0 = w_cnt;
    for (int i = 0; i < 8; i++) push(8'($urandom));
    wait_writes(w0 + 8);
    check_writes();
    st_rand = 1'b0;

    // Reset while waiting for STATUS with three bytes queued
    st_val = 1'b0;
    push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
    wait_read(4'h1, a);
    @(posedge clk_i);
    #2 arst_n_i = 1'b0;
    #1;
    chk("mid_rst_read", 32'(avm_read_o), 32'd0);
    chk("mid_rst_write", 32'(avm_write_o), 32'd0);
    chk("mid_rst_addr", 32'(avm_address_o), 32'h1);
    chk("mid_rst_ready", 32'(s_tx_ready_o), 32'd1);
    exp_q.delete();
    w0 = w_cnt;
    #5;
    @(negedge clk_i) arst_n_i = 1'b1;
    st_val = 1'b1;
    repeat (60) @(negedge clk_i);
    chk("no_write_after_rst", 32'(w_cnt), 32'(w0));
    chk("idle_after_rst", 32'(busy_o), 32'd0);
    chk("protocol", 32'(proto_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_avms_master.md
Name: uart_avms_master

Overview:
- Avalon-MM master that drives the uart_core register interface so the rest of the design can use plain byte streams instead of bus transactions.
- TX side: buffers bytes from a valid/ready stream in a FIFO. For each byte it polls STATUS until tx_ready is set, then writes TXDATA.
- RX side: when IRQ_event is high, reads RXDATA, which also clears the IRQ, and presents the byte on a valid/ready output.
- Sits directly upstream of uart_core on its avms_* port.

Parameters:
- TX_DEPTH, 16: TX FIFO entries; power of two, ≥2.
- READ_LATENCY, 1: cycles from the read strobe to valid avm_readdata_i; range 1..3.
- POLL_GAP, 3: idle cycles inserted before every STATUS poll.

Ports:
- clk_i  in  1  system clock
- arst_n_i  in  1  reset, asynchronous, active-low
- s_tx_data_i  in  8  TX byte
- s_tx_valid_i  in  1  TX byte valid
- s_tx_ready_o  out  1  FIFO not full
- m_rx_data_o  out  8  received byte
- m_rx_valid_o  out  1  received byte valid
- m_rx_ready_i  in  1  consumer accepts byte
- avm_address_o  out  4  uart_core register address
- avm_byteenable_o  out  1  byte enable
- avm_read_o  out  1  read strobe
- avm_write_o  out  1  write strobe
- avm_writedata_o  out  8  write data
- avm_readdata_i  in  8  read data
- irq_i  in  1  uart_core IRQ_event, level
- rx_drop_cnt_o  out  8  saturating count of dropped RX bytes
- busy_o  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Clock and reset: one clock, clk_i; reset arst_n_i is asynchronous and active-low.
- Reset values: all strobes 0; avm_address_o=4'h1; avm_writedata_o=0; avm_byteenable_o=0; m_rx_valid_o=0; m_rx_data_o=0; rx_drop_cnt_o=0; FIFO empty; FSM in IDLE; gap counter=POLL_GAP.
- Reset asserted mid-transaction: strobes drop immediately; the pending byte is lost; the FIFO is flushed.
- uart_core register map: 0=TXDATA (write); 1=STATUS (read; bit0 tx_ready); 2=RXDATA (read; the read clears IRQ_event).
- All outputs are registered.
- avm_read_o and avm_write_o:
  - each is a single-cycle strobe, never both high in the same cycle;
  - address, data and byteenable are valid in the strobe cycle;
  - avm_address_o returns to 4'h1 whenever no strobe is active.
- TX FIFO:
  - s_tx_ready_o = !full;
  - push on s_tx_valid_i && s_tx_ready_o;
  - pop in the TX_WR cycle;
  - simultaneous push and pop leaves the count unchanged;
  - pointers wrap modulo TX_DEPTH.
- FSM states: IDLE, GAP, ST_RD, ST_WAIT, TX_WR, RX_RD, RX_WAIT.
- IDLE:
  - if irq_i && !irq_mask -> RX_RD (RX has priority);
  - else if FIFO not empty -> GAP;
  - else stay in IDLE.
- GAP: count down POLL_GAP cycles, then -> ST_RD. When POLL_GAP=0, go directly to ST_RD.
- ST_RD: read strobe, address 1, for 1 cycle -> ST_WAIT.
- ST_WAIT:
  - wait READ_LATENCY cycles, then sample avm_readdata_i;
  - bit0=1 -> TX_WR;
  - bit0=0 -> IDLE, so irq_i is rechecked before the next poll.
- TX_WR: write strobe, address 0, writedata = FIFO head, byteenable=1, for 1 cycle; pop the FIFO -> IDLE.
- RX_RD: read strobe, address 2, for 1 cycle -> RX_WAIT.
- RX_WAIT:
  - wait READ_LATENCY cycles, then capture avm_readdata_i;
  - set irq_mask for 2 cycles so the IRQ is not re-served while uart_core deasserts it;
  - -> IDLE.
- RX capture:
  - if m_rx_valid_o is low, or m_rx_valid_o && m_rx_ready_i in the capture cycle: load m_rx_data_o and set m_rx_valid_o=1;
  - otherwise drop the byte and increment rx_drop_cnt_o, saturating at 255.
- RX output handshake: m_rx_valid_o clears on m_rx_ready_i unless a new byte loads in the same cycle; m_rx_data_o is held stable while valid && !ready.
- Every TX byte is written exactly once, in FIFO order; there are no writes without a preceding STATUS read with bit0=1.

Test Plan:
- Push 0x48, 0x45, 0x4C with STATUS always 0x01 -> three TXDATA writes, address 0, data 0x48/0x45/0x4C in order. Each write is preceded by a STATUS read at address 1 and ≥3 idle cycles.
- STATUS returns 0x00 for 5 polls, then 0x01 -> exactly 6 STATUS reads, then 1 write; no write while bit0=0.
- Push 16 bytes with STATUS 0x00 -> s_tx_ready_o=0 after the 16th push; a 17th valid is not accepted. Set STATUS 0x01 -> ready rises after the first pop.
- irq_i=1 with RXDATA=0x5A while the FIFO is non-empty -> RXDATA read at address 2 happens before the next STATUS poll; m_rx_valid_o=1 with data 0x5A.
- m_rx_ready_i held 0, two IRQs deliver 0x11 then 0x22 -> m_rx_data_o stays 0x11 and rx_drop_cnt_o=1.
- arst_n_i pulsed low during ST_WAIT with 3 bytes queued -> strobes 0 and address 4'h1 immediately; FIFO empty; no write after release.
